// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: one outstanding imem transaction, redirect/kill handling, decode valid/ready.
// REQ->inst_valid in 2 cycles at best; decode stalls hold OUT with stable outputs.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        inst_fault,
  output logic [31:0] pc
);

  localparam logic [2:0] BOOT = 3'd0;
  localparam logic [2:0] IDLE = 3'd1;
  localparam logic [2:0] REQ  = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc_q;
  logic        kill;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        fault_q;
  logic        misaligned;

  assign misaligned    = (pc_q[1:0] != 2'b00);
  assign imem_req      = (state == REQ) && !misaligned;
  assign imem_addr     = pc_q;
  assign inst_valid    = (state == OUT);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_pc_plus4 = inst_pc_q + 32'd4;
  assign inst_fault    = fault_q;
  assign pc            = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      pc_q      <= RESET_PC;
      kill      <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= halt ? IDLE : REQ;

        IDLE: begin
          if (redirect_valid) pc_q <= redirect_target;
          if (!halt) state <= REQ;
        end

        REQ: begin
          if (misaligned) begin
            // A redirect supersedes the fault; the misaligned PC is already wrong-path.
            if (redirect_valid) begin
              pc_q  <= redirect_target;
              state <= halt ? IDLE : REQ;
            end else begin
              inst_q    <= NOP_INST;
              fault_q   <= 1'b1;
              inst_pc_q <= pc_q;
              state     <= OUT;
            end
          end else if (imem_gnt) begin
            state <= WAIT;
            if (redirect_valid) begin
              pc_q <= redirect_target;
              kill <= 1'b1;
            end
          end else if (redirect_valid) begin
            pc_q <= redirect_target;
            if (halt) state <= IDLE;
          end else if (halt) begin
            state <= IDLE;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc_q <= redirect_target;
            if (imem_rvalid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              inst_q    <= imem_rdata;
              fault_q   <= imem_err;
              inst_pc_q <= pc_q;
              state     <= OUT;
            end
          end
        end

        OUT: begin
          // Redirect wins over the handshake: the held instruction is wrong-path.
          if (redirect_valid) begin
            pc_q  <= redirect_target;
            state <= halt ? IDLE : REQ;
          end else if (inst_ready) begin
            pc_q  <= pc_q + 32'd4;
            state <= halt ? IDLE : REQ;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: architectural-PC model plus memory responder, directed scenarios.
module tb_ifu_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, redirect_valid, inst_ready;
  logic [31:0] redirect_target;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_fault;
  logic [31:0] inst, inst_pc, inst_pc_plus4, pc;

  ifu_fetch_ctrl dut (
    .clk(clk), .rst(rst), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4), .inst_fault(inst_fault),
    .pc(pc)
  );

  // Second instance exercising a reset PC at the top of the address space.
  logic        w_req, w_rvalid, w_valid, w_fault, w_pend;
  logic [31:0] w_addr, w_inst, w_inst_pc, w_pc4, w_pc;
  logic        w_zero = 1'b0;
  logic        w_one = 1'b1;
  logic [31:0] w_zero32 = 32'h0;
  logic [31:0] w_rdata = 32'h0000_0013;
  logic [31:0] wlog[$];

  ifu_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .halt(w_zero),
    .redirect_valid(w_zero), .redirect_target(w_zero32),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_one),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .imem_err(w_zero),
    .inst_valid(w_valid), .inst_ready(w_one), .inst(w_inst),
    .inst_pc(w_inst_pc), .inst_pc_plus4(w_pc4), .inst_fault(w_fault),
    .pc(w_pc)
  );

  always @(negedge clk) begin
    if (!rst) begin
      w_rvalid = 1'b0;
      w_pend   = 1'b0;
    end else begin
      w_rvalid = w_pend;
      w_pend   = w_req;
      if (w_req) wlog.push_back(w_addr);
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: event never arrived within its cycle budget", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  // Memory responder and architectural model state.
  bit          pending;
  int          cnt, req_age, cyc;
  int          gnt_wait = 0;
  int          rsp_lat = 1;
  logic [31:0] paddr, gaddr;
  logic [31:0] err_addr = 32'hFFFF_FFF0;
  logic [31:0] mpc;
  logic [31:0] dlog[$];
  logic [31:0] glog[$];
  int          valid_t[$];
  int          first_req = -1;
  bit          prev_hold, prev_v;
  logic [31:0] exp_inst;
  logic        exp_fault;

  always @(negedge clk) begin
    if (!rst) begin
      pending = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
      mpc = 32'h0; req_age = 0; prev_hold = 0; prev_v = 0; cyc = 0;
    end else begin
      cyc++;
      check("pc", pc, mpc);
      check("imem_addr", imem_addr, mpc);
      if (prev_hold) check("hold_valid", inst_valid, 1);
      if (imem_rvalid) pending = 0;
      if (imem_gnt) begin
        pending = 1; paddr = gaddr; cnt = rsp_lat; glog.push_back(gaddr);
      end
      if (imem_req) begin
        check("req_aligned", mpc[1:0], 0);
        check("one_outstanding", pending, 0);
        if (first_req < 0) first_req = cyc;
      end
      if (inst_valid) begin
        if (mpc[1:0] != 2'b00) begin
          exp_inst = 32'h0000_0013; exp_fault = 1'b1;
        end else begin
          exp_inst = mem_word(mpc); exp_fault = (mpc == err_addr);
        end
        check("inst", inst, exp_inst);
        check("inst_pc", inst_pc, mpc);
        check("inst_pc_plus4", inst_pc_plus4, mpc + 32'd4);
        check("inst_fault", inst_fault, exp_fault);
        if (!prev_v) valid_t.push_back(cyc);
      end
      prev_v = inst_valid;
      imem_gnt = 0; imem_rvalid = 0; imem_err = 0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1; imem_rdata = mem_word(paddr); imem_err = (paddr == err_addr);
        end
      end
      if (imem_req && !pending) begin
        if (req_age >= gnt_wait) begin
          imem_gnt = 1; gaddr = imem_addr;
        end
        req_age++;
      end else begin
        req_age = 0;
      end
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      if (redirect_valid) mpc = redirect_target;
      else if (inst_valid && inst_ready) begin
        dlog.push_back(mpc); mpc = mpc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (inst_valid) found = 1;
      else tick();
    end
    if (!found) timeout(name);
  endtask

  task automatic wait_req(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req) found = 1;
      else tick();
    end
    if (!found) timeout(name);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1; redirect_target = t;
    tick();
    redirect_valid = 0;
  endtask

  task automatic park();
    halt = 1;
    repeat (8) tick();
    check("park_req", imem_req, 0);
    check("park_valid", inst_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit done;
    rst = 0; halt = 0; redirect_valid = 0; redirect_target = 0; inst_ready = 1;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fault", inst_fault, 0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #3 rst = 1;

    // Boot and back-to-back fetch with an always-ready decode.
    tick();
    wait_valid("boot_valid");
    check("boot_inst", inst, 32'h0050_0093);
    check("boot_inst_pc", inst_pc, 32'h0);
    check("boot_pc_plus4", inst_pc_plus4, 32'h4);
    check("boot_fault", inst_fault, 0);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dlog.size() >= 2 && glog.size() >= 3) done = 1;
      else tick();
    end
    if (!done) timeout("boot_seq");
    check("boot_addr0", glog[0], 32'h0);
    check("boot_addr1", glog[1], 32'h4);
    check("boot_addr2", glog[2], 32'h8);
    check("boot_dpc0", dlog[0], 32'h0);
    check("boot_dpc1", dlog[1], 32'h4);
    check("latency", valid_t[0] - first_req, 2);
    check("throughput", valid_t[1] - valid_t[0], 3);

    // Decode stall holds the instruction.
    park();
    redirect(32'h0);
    inst_ready = 0; halt = 0;
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", inst_valid, 1);
      check("stall_inst", inst, 32'h0050_0093);
      check("stall_inst_pc", inst_pc, 32'h0);
      check("stall_req", imem_req, 0);
      check("stall_pc", pc, 32'h0);
    end
    inst_ready = 1;
    tick();
    check("stall_pc_adv", pc, 32'h4);
    check("stall_valid_drop", inst_valid, 0);

    // Redirect in WAIT one cycle before the response.
    park();
    rsp_lat = 2; inst_ready = 0;
    redirect(32'h8);
    halt = 0;
    wait_req("wait_req8");
    check("wait_addr8", imem_addr, 32'h8);
    tick();
    check("wait1_req", imem_req, 0);
    redirect(32'h100);
    check("kill_valid0", inst_valid, 0);
    check("kill_pc", pc, 32'h100);
    tick();
    check("kill_valid1", inst_valid, 0);
    check("kill_req", imem_req, 1);
    check("kill_addr", imem_addr, 32'h100);
    inst_ready = 1;
    wait_valid("kill_deliver");
    check("kill_inst_pc", inst_pc, 32'h100);
    check("kill_inst", inst, 32'h0051_0093);
    check("kill_glog_old", glog[glog.size()-2], 32'h8);
    check("kill_glog_new", glog[glog.size()-1], 32'h100);

    // Redirect in OUT with ready high in the same cycle.
    n0 = dlog.size();
    redirect(32'h200);
    check("outredir_pc", pc, 32'h200);
    check("outredir_valid", inst_valid, 0);
    check("outredir_count", dlog.size(), n0);
    wait_req("outredir_req");
    check("outredir_addr", imem_addr, 32'h200);
    wait_valid("outredir_deliver");
    check("outredir_inst_pc", inst_pc, 32'h200);

    // Misaligned target, then a bus error.
    redirect(32'h102);
    check("mis_req", imem_req, 0);
    check("mis_pc", pc, 32'h102);
    tick();
    check("mis_valid", inst_valid, 1);
    check("mis_inst", inst, 32'h0000_0013);
    check("mis_fault", inst_fault, 1);
    check("mis_inst_pc", inst_pc, 32'h102);
    err_addr = 32'h300;
    redirect(32'h300);
    wait_valid("err_deliver");
    check("err_fault", inst_fault, 1);
    check("err_inst", inst, 32'h0053_0093);
    check("err_inst_pc", inst_pc, 32'h300);

    // Halt during an ungranted request, then resume at the same PC.
    gnt_wait = 3;
    wait_req("halt_req");
    check("halt_req_addr", imem_addr, 32'h304);
    halt = 1;
    tick();
    check("halt_idle_req", imem_req, 0);
    check("halt_idle_pc", pc, 32'h304);
    check("halt_idle_valid", inst_valid, 0);
    repeat (3) begin
      tick();
      check("halt_hold_req", imem_req, 0);
    end
    gnt_wait = 0; halt = 0;
    wait_req("resume_req");
    check("resume_addr", imem_addr, 32'h304);
    wait_valid("resume_deliver");
    check("resume_inst_pc", inst_pc, 32'h304);

    // Reset PC at the top of the address space wraps to zero.
    check("wrap_count", wlog.size() >= 2, 1);
    check("wrap_addr0", wlog[0], 32'hFFFF_FFFC);
    check("wrap_addr1", wlog[1], 32'h0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
